// File: rtl/hls_snn_izikevich_hls_deadlock_monitor_param.sv
// hls_snn_izikevich_hls_deadlock_monitor_param
//
// Deadlock monitor for one level of the HLS SNN dataflow hierarchy. It merges
// the AXIS channel block flags, the block outputs of child monitors and the
// instance idle flags into one blocking condition. block is raised only after
// that condition has held for THRESH consecutive clock edges.
//
// It also reports:
//   - the lowest contributing AXIS channel at the moment block is entered;
//   - a saturating count of how many times block has been entered.
//
// Build option:
//   DEADLOCK_MON_STICKY_EN - when defined, BLOCKED latches. Only clear or reset
//                            can leave it, so at most one event is counted per
//                            clear.
//
// State table:
//   state      | meaning
//   ST_IDLE    | no blocking condition observed
//   ST_ARMING  | blocking condition seen; persistence count running
//   ST_BLOCKED | condition persisted THRESH edges; block asserted

module hls_snn_izikevich_hls_deadlock_monitor_param #(
    parameter int                         N_AXIS   = 6,
    parameter int                         N_INST   = 4,
    parameter int                         N_GRP    = 2,
    parameter logic [N_AXIS-1:0]          CUR_MASK = 6'b000001,
    parameter logic [N_GRP*N_AXIS-1:0]    GRP_MASK = 12'b111100_000010,
    parameter int                         THRESH   = 4,
    parameter int                         CNT_W    = 8,
    parameter int                         IDX_W    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_GRP-1:0]  inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_pending,
    output logic [IDX_W-1:0]  blocker_idx,
    output logic [CNT_W-1:0]  event_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMING  = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    // Count value held on the edge that completes persistence.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  evt_q,   evt_d;

    logic [N_AXIS-1:0] contrib;
    logic              raw;
    logic [IDX_W-1:0]  lowest_idx;
    logic              enter_blocked;

    // Channels owned here count directly. A channel owned by a child counts
    // only while that child reports block.
    always_comb begin
        contrib = axis_block_sigs & CUR_MASK;
        for (int g = 0; g < N_GRP; g++) begin
            contrib = contrib
                    | ({N_AXIS{inst_block_sigs[g]}}
                       & axis_block_sigs
                       & GRP_MASK[g*N_AXIS +: N_AXIS]);
        end
    end

    // A design whose instances are all idle has simply finished, so it is
    // never reported as deadlocked.
    assign raw = (|contrib) & ~(&inst_idle_sigs);

    // Priority encoder: lowest set bit of contrib wins.
    always_comb begin
        lowest_idx = '0;
        for (int i = N_AXIS - 1; i >= 0; i--) begin
            if (contrib[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    // Next-state logic for the persistence FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        enter_blocked = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (raw) begin
                    cnt_d = CNT_ONE;
                    if (THRESH == 1) begin
                        state_d       = ST_BLOCKED;
                        enter_blocked = 1'b1;
                    end else begin
                        state_d = ST_ARMING;
                    end
                end
            end
            ST_ARMING: begin
                if (!raw) begin
                    // One quiet cycle restarts persistence from zero.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_BLOCKED;
                    enter_blocked = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BLOCKED: begin
`ifdef DEADLOCK_MON_STICKY_EN
                // Latched. Only clear or reset leaves this state.
                state_d = ST_BLOCKED;
`else
                if (!raw) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture the blocker index and bump the event count on entry to BLOCKED.
    always_comb begin
        idx_d = idx_q;
        evt_d = evt_q;
        if (enter_blocked) begin
            idx_d = lowest_idx;
            if (evt_q != {CNT_W{1'b1}}) begin
                evt_d = evt_q + CNT_ONE;
            end
        end
    end

    // State registers. Reset takes priority over clear, and clear over the FSM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            evt_q   <= '0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            evt_q   <= evt_d;
        end
    end

    assign block         = (state_q == ST_BLOCKED);
    assign block_pending = (state_q == ST_ARMING);
    assign blocker_idx   = idx_q;
    assign event_count   = evt_q;

endmodule

// File: tb/tb_hls_snn_izikevich_hls_deadlock_monitor_param.sv
// Testbench for hls_snn_izikevich_hls_deadlock_monitor_param (default parameters).
//
// The reference model tracks how many consecutive edges have sampled the
// blocking condition. block means that run length has reached THRESH.

module tb_hls_snn_izikevich_hls_deadlock_monitor_param;

    localparam int THRESH = 4;
    localparam int EVT_MAX = 255;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic [5:0] axis;
    logic [3:0] idle;
    logic [1:0] iblk;
    logic       block;
    logic       block_pending;
    logic [2:0] blocker_idx;
    logic [7:0] event_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    int   m_run     = 0;
    logic m_blocked = 1'b0;
    int   m_idx     = 0;
    int   m_evt     = 0;

    always #5 clock = ~clock;

    hls_snn_izikevich_hls_deadlock_monitor_param dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis),
        .inst_idle_sigs  (idle),
        .inst_block_sigs (iblk),
        .clear           (clear),
        .block           (block),
        .block_pending   (block_pending),
        .blocker_idx     (blocker_idx),
        .event_count     (event_count)
    );

    // Contributing channels. Channel 0 is owned by this level. Channel 1 is
    // gated by child 0, and channels 2..5 are gated by child 1.
    function automatic logic [5:0] contrib_of(input logic [5:0] a, input logic [1:0] ib);
        logic [5:0] c;
        c = a & 6'b000001;
        if (ib[0]) c = c | (a & 6'b000010);
        if (ib[1]) c = c | (a & 6'b111100);
        return c;
    endfunction

    function automatic int lowest_bit(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic c, input logic [5:0] a,
                                input logic [3:0] id, input logic [1:0] ib);
        logic [5:0] con;
        logic       raw;
        if (!r || c) begin
            m_run     = 0;
            m_blocked = 1'b0;
            m_idx     = 0;
            m_evt     = 0;
        end else begin
            con = contrib_of(a, ib);
            raw = (con != 6'b0) && (id != 4'hF);
`ifdef DEADLOCK_MON_STICKY_EN
            if (!m_blocked) begin
`else
            begin
`endif
                if (raw) begin
                    m_run++;
                    if (m_run == THRESH) begin
                        m_blocked = 1'b1;
                        m_idx     = lowest_bit(con);
                        if (m_evt < EVT_MAX) m_evt++;
                    end
                end else begin
                    m_run     = 0;
                    m_blocked = 1'b0;
                end
            end
        end
    endtask

    // Apply inputs for one edge, advance the model, then check #1 after the edge.
    task automatic step(input logic r, input logic c, input logic [5:0] a,
                        input logic [3:0] id, input logic [1:0] ib);
        reset = r;
        clear = c;
        axis  = a;
        idle  = id;
        iblk  = ib;
        @(posedge clock);
        model_update(r, c, a, id, ib);
        #1;
        check("block",         32'(block),         32'(m_blocked));
        check("block_pending", 32'(block_pending), 32'((m_run > 0) && !m_blocked));
        check("blocker_idx",   32'(blocker_idx),   32'(m_idx));
        check("event_count",   32'(event_count),   32'(m_evt));
    endtask

    initial begin
        logic [5:0] ra;
        logic [3:0] ri;
        logic [1:0] rb;
        logic       rc;
        logic       rr;

        reset = 1'b0;
        clear = 1'b0;
        axis  = 6'h3F;
        idle  = 4'h0;
        iblk  = 2'b00;

        // Reset held for two edges while every channel reports blocked.
        step(1'b0, 1'b0, 6'h3F, 4'h0, 2'b00);
        step(1'b0, 1'b0, 6'h3F, 4'h0, 2'b00);

        // Owned channel held: pending after edge 1, block after edge 4.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 6'h01, 4'h0, 2'b00);
        check("spec_blk_idx0", 32'(blocker_idx), 32'd0);
        check("spec_evt1",     32'(event_count), 32'd1);
        step(1'b1, 1'b0, 6'h00, 4'h0, 2'b00);

        // Three edges, then a gap: never blocks and the count is unchanged.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 6'h01, 4'h0, 2'b00);
        step(1'b1, 1'b0, 6'h00, 4'h0, 2'b00);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 6'h01, 4'h0, 2'b00);
        step(1'b1, 1'b0, 6'h00, 4'h0, 2'b00);

        // Channel 4 counts only while child 1 reports block.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 6'h10, 4'h0, 2'b10);
        check("spec_grp_blk", 32'(block),       32'd1);
        check("spec_grp_idx", 32'(blocker_idx), 32'd4);
        step(1'b1, 1'b0, 6'h00, 4'h0, 2'b10);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 6'h10, 4'h0, 2'b00);
        // Channel 1 counts only through child 0.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 6'h02, 4'h0, 2'b10);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 6'h02, 4'h0, 2'b01);
        step(1'b1, 1'b0, 6'h00, 4'h0, 2'b00);

        // All instances idle: never deadlocked.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 6'h01, 4'hF, 2'b00);

        // Enter BLOCKED, then the condition drops.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 6'h3F, 4'h7, 2'b11);
        step(1'b1, 1'b0, 6'h00, 4'h0, 2'b00);

        // clear and raw on the same edge: clear wins.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 6'h01, 4'h0, 2'b00);
        step(1'b1, 1'b1, 6'h01, 4'h0, 2'b00);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 6'h01, 4'h0, 2'b00);
        step(1'b1, 1'b1, 6'h00, 4'h0, 2'b00);

        // Randomized traffic; inputs tend to hold so that long runs occur.
        ra = 6'h00;
        ri = 4'h0;
        rb = 2'b00;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 4) == 0) ra = 6'($urandom);
            if ($urandom_range(0, 9) == 0) ri = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 5) == 0) rb = 2'($urandom);
            rc = ($urandom_range(0, 59) == 0);
            rr = ($urandom_range(0, 149) != 0);
            step(rr, rc, ra, ri, rb);
        end

        // Drive event_count into saturation.
        step(1'b1, 1'b1, 6'h00, 4'h0, 2'b00);
        for (int e = 0; e < 260; e++) begin
            for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 6'h01, 4'h0, 2'b00);
            step(1'b1, 1'b0, 6'h00, 4'h0, 2'b00);
        end
        check("evt_saturated", 32'(event_count), 32'd255);
        step(1'b1, 1'b1, 6'h00, 4'h0, 2'b00);
        check("evt_cleared", 32'(event_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
